// File: rtl/gs_ddram_arbiter.sv
// Two byte-wide requesters (GS memory, preload path) sharing one 64-bit DDR3 port.
// Optional per-port read line caches with write-through: define GS_DDRAM_ARB_CACHE_EN.
module gs_ddram_arbiter #(
    parameter logic [28:0] BASE_ADDR = 29'h0600000,
    parameter logic        PRIO_A    = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [20:0] a_addr,
    input  logic [7:0]  a_din,
    input  logic        a_rd,
    input  logic        a_wr,
    output logic [7:0]  a_dout,
    output logic        a_ready,
    input  logic [20:0] b_addr,
    input  logic [7:0]  b_din,
    input  logic        b_rd,
    input  logic        b_wr,
    output logic [7:0]  b_dout,
    output logic        b_ready,
    input  logic        DDRAM_BUSY,
    output logic [28:0] DDRAM_ADDR,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic        DDRAM_RD,
    output logic        DDRAM_WE,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY
);
    typedef enum logic [1:0] {IDLE, RD, RWAIT, WR} state_t;
    state_t r_state, w_stateNext;

    logic [20:0] w_inAddr [2];
    logic [7:0]  w_inDin  [2];
    logic        w_inRd   [2];
    logic        w_inWr   [2];

    logic        r_rdPrev [2];
    logic        r_wrPrev [2];
    logic        r_pend   [2];
    logic        r_isWr   [2];
    logic        r_ready  [2];
    logic [20:0] r_addr   [2];
    logic [7:0]  r_din    [2];
    logic [7:0]  r_dout   [2];

    logic        r_gnt;
    logic        r_prioA;
    logic        r_ddrRd;
    logic        r_ddrWe;
    logic [28:0] r_ddrAddr;
    logic [63:0] r_ddrDin;
    logic [7:0]  r_ddrBe;

    logic        w_hit     [2];
    logic [7:0]  w_hitByte [2];
    logic        w_cand    [2];
    logic        w_grant;
    logic        w_grantPort;
    logic        w_rdDone;
    logic        w_wrDone;
    logic [2:0]  w_lane;
    logic [7:0]  w_rdByte;

    assign w_inAddr[0] = a_addr;
    assign w_inAddr[1] = b_addr;
    assign w_inDin[0]  = a_din;
    assign w_inDin[1]  = b_din;
    assign w_inRd[0]   = a_rd;
    assign w_inRd[1]   = b_rd;
    assign w_inWr[0]   = a_wr;
    assign w_inWr[1]   = b_wr;

    assign a_dout  = r_dout[0];
    assign a_ready = r_ready[0];
    assign b_dout  = r_dout[1];
    assign b_ready = r_ready[1];

    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_RD       = r_ddrRd;
    assign DDRAM_WE       = r_ddrWe;
    assign DDRAM_ADDR     = r_ddrAddr;
    assign DDRAM_DIN      = r_ddrDin;
    assign DDRAM_BE       = r_ddrBe;

    assign w_lane   = r_addr[r_gnt][2:0];
    assign w_rdByte = DDRAM_DOUT[{w_lane, 3'b000} +: 8];
    assign w_rdDone = (r_state == RWAIT) && DDRAM_DOUT_READY;
    assign w_wrDone = (r_state == WR) && !DDRAM_BUSY;

`ifdef GS_DDRAM_ARB_CACHE_EN
    logic        r_lineValid [2];
    logic [17:0] r_lineTag   [2];
    logic [63:0] r_line      [2];

    // A port already holding the DDR3 grant is never treated as a hit.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_hit[p] = r_pend[p] && !r_isWr[p] && r_lineValid[p]
                       && (r_lineTag[p] == r_addr[p][20:3])
                       && !((r_state != IDLE) && (r_gnt == 1'(p)));
            w_hitByte[p] = r_line[p][{r_addr[p][2:0], 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                r_lineValid[p] <= 1'b0;
                r_lineTag[p]   <= '0;
                r_line[p]      <= '0;
            end
        end else if (w_rdDone) begin
            r_lineValid[r_gnt] <= 1'b1;
            r_lineTag[r_gnt]   <= r_addr[r_gnt][20:3];
            r_line[r_gnt]      <= DDRAM_DOUT;
        end else if (w_wrDone) begin
            for (int p = 0; p < 2; p++) begin
                if (r_lineValid[p] && (r_lineTag[p] == r_addr[r_gnt][20:3]))
                    r_line[p][{w_lane, 3'b000} +: 8] <= r_din[r_gnt];
            end
        end
    end
`else
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_hit[p]     = 1'b0;
            w_hitByte[p] = 8'h00;
        end
    end
`endif

    always_comb begin
        w_stateNext = r_state;
        w_grant     = 1'b0;
        w_grantPort = 1'b0;
        for (int p = 0; p < 2; p++)
            w_cand[p] = r_pend[p] && !w_hit[p];
        case (r_state)
            IDLE: begin
                if (w_cand[0] || w_cand[1]) begin
                    w_grant     = 1'b1;
                    w_grantPort = (w_cand[0] && w_cand[1]) ? !r_prioA : w_cand[1];
                    w_stateNext = r_isWr[w_grantPort] ? WR : RD;
                end
            end
            RD:      if (!DDRAM_BUSY) w_stateNext = RWAIT;
            RWAIT:   if (DDRAM_DOUT_READY) w_stateNext = IDLE;
            WR:      if (!DDRAM_BUSY) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_stateNext;
    end

    // Strobes are registered so they drop asynchronously on reset.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_gnt     <= 1'b0;
            r_prioA   <= PRIO_A;
            r_ddrRd   <= 1'b0;
            r_ddrWe   <= 1'b0;
            r_ddrAddr <= '0;
            r_ddrDin  <= '0;
            r_ddrBe   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_gnt     <= w_grantPort;
                        r_ddrAddr <= BASE_ADDR + {11'd0, r_addr[w_grantPort][20:3]};
                        if (w_cand[0] && w_cand[1])
                            r_prioA <= !r_prioA;
                        if (r_isWr[w_grantPort]) begin
                            r_ddrWe  <= 1'b1;
                            r_ddrDin <= {8{r_din[w_grantPort]}};
                            r_ddrBe  <= 8'h01 << r_addr[w_grantPort][2:0];
                        end else begin
                            r_ddrRd  <= 1'b1;
                        end
                    end
                end
                RD:      if (!DDRAM_BUSY) r_ddrRd <= 1'b0;
                WR:      if (!DDRAM_BUSY) r_ddrWe <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                r_rdPrev[p] <= 1'b0;
                r_wrPrev[p] <= 1'b0;
                r_pend[p]   <= 1'b0;
                r_isWr[p]   <= 1'b0;
                r_ready[p]  <= 1'b1;
                r_addr[p]   <= '0;
                r_din[p]    <= '0;
                r_dout[p]   <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_rdPrev[p] <= w_inRd[p];
                r_wrPrev[p] <= w_inWr[p];
                if (!r_pend[p]) begin
                    if ((w_inRd[p] && !r_rdPrev[p]) || (w_inWr[p] && !r_wrPrev[p])) begin
                        r_addr[p]  <= w_inAddr[p];
                        r_din[p]   <= w_inDin[p];
                        r_isWr[p]  <= w_inWr[p] && !r_wrPrev[p];
                        r_pend[p]  <= 1'b1;
                        r_ready[p] <= 1'b0;
                    end
                end else if (w_hit[p]) begin
                    r_dout[p]  <= w_hitByte[p];
                    r_ready[p] <= 1'b1;
                    r_pend[p]  <= 1'b0;
                end else if ((r_gnt == 1'(p)) && (w_rdDone || w_wrDone)) begin
                    if (w_rdDone)
                        r_dout[p] <= w_rdByte;
                    r_ready[p] <= 1'b1;
                    r_pend[p]  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/gs_ddram_arbiter.md
Name: gs_ddram_arbiter

Overview:
- Shares one 64-bit DDR3 port between two byte-wide requesters.
- Port A is General Sound memory, 21-bit address, up to 2 MB.
- Port B is the GS ROM/RAM preload path, e.g. an ioctl loader or a debug reader.
- Round-robin arbitration, byte-to-qword lane steering, and per-port single-line read caching with write-through coherence.
- Sits between the tsconf GS memory signals and the DDRAM_* top-level bus.

Parameters:
- BASE_ADDR, 29'h0600000: DDR3 qword address of GS byte 0.
- PRIO_A, 1: 1 gives port A the win on a simultaneous first request after reset; 0 gives port B the win.

Ports:
- clk_sys  in  1  system clock; DDRAM_CLK is driven from the same clock outside this block.
- reset  in  1  asynchronous, active-high.
- a_addr  in  21  port A byte address.
- a_din  in  8  port A write data.
- a_rd  in  1  port A read request; level signal, rising edge starts an access.
- a_wr  in  1  port A write request; level signal, rising edge starts an access.
- a_dout  out  8  port A read data.
- a_ready  out  1  port A idle/complete.
- b_addr, b_din, b_rd, b_wr, b_dout, b_ready: same as port A, for port B.
- DDRAM_BUSY  in  1  DDR3 waitrequest.
- DDRAM_ADDR  out  29  DDR3 qword address.
- DDRAM_BURSTCNT  out  8  constant 1.
- DDRAM_RD  out  1  DDR3 read strobe.
- DDRAM_WE  out  1  DDR3 write strobe.
- DDRAM_DIN  out  64  DDR3 write data.
- DDRAM_BE  out  8  DDR3 byte enables.
- DDRAM_DOUT  in  64  DDR3 read data.
- DDRAM_DOUT_READY  in  1  DDR3 read data valid.

Behaviour:
- Reset values: DDRAM_RD=0, DDRAM_WE=0, DDRAM_ADDR=0, DDRAM_DIN=0, DDRAM_BE=0, a/b_dout=0, a/b_ready=1, both caches invalid, round-robin pointer=PRIO_A, FSM=IDLE.
- Request capture, per port:
  - Registered copies of rd and wr are kept; a 0->1 transition is a new request.
  - On detection: latch addr, din and type; set pending; drop ready on the next edge.
  - Edges arriving while pending are ignored.
  - rd and wr rising in the same cycle are treated as a write.
- Cache hit path, per port:
  - Read, valid line, tag == addr[20:3]: dout <= line byte addr[2:0], ready=1 one cycle after ready fell. No DDR3 traffic, no arbitration.
- Arbitration, in IDLE only:
  - Candidates are pending requests that are not cache hits.
  - If both are candidates, grant the port opposite the pointer's last grant, then flip the pointer.
  - A single candidate wins without flipping the pointer.
- Address mapping: DDRAM_ADDR = BASE_ADDR + addr[20:3], 29-bit wrap.
- Write lanes: DDRAM_DIN = {8{din}}, DDRAM_BE = 8'h01 << addr[2:0].
- FSM states:
  - IDLE: on a read grant go to RD; on a write grant go to WR.
  - RD: assert DDRAM_RD with the address. Hold while DDRAM_BUSY. In the first cycle with !BUSY, drop RD and go to RWAIT.
  - RWAIT: wait for DDRAM_DOUT_READY. Then:
    - load the granted port's line and tag and set valid;
    - dout <= selected byte; ready <= 1; clear pending; go to IDLE.
  - WR: assert DDRAM_WE with DIN and BE. Hold while BUSY. On !BUSY:
    - drop WE; ready <= 1; clear pending; go to IDLE;
    - write-through: in any valid line (either port) whose tag matches, patch byte addr[2:0].
- Latency:
  - Miss read: 2 cycles plus DDR3 latency from the request edge to ready.
  - Hit read: ready returns to 1 two cycles after the request edge.
- Boundary conditions:
  - DDRAM_DOUT_READY outside RWAIT is ignored. This covers stale data after a reset mid-read.
  - Asynchronous reset in any state aborts the access, drops strobes immediately, and invalidates the caches.
  - Address 21'h1FFFFF maps to BASE_ADDR + 18'h3FFFF, lane 7.
  - A request arriving in the same cycle the FSM returns to IDLE competes in the next IDLE cycle.

Optional Feature:
- Macro: GS_DDRAM_ARB_CACHE_EN.
- Defined: per-port line caches and the hit path exist as described above.
- Undefined: no cache storage. Every read goes through RD/RWAIT. Hit-latency rules and write patching are removed. Arbitration and the FSM are otherwise identical.

Test Plan:
- Reset, then A write 8'h5A to 21'h000013 -> one DDRAM_WE, DDRAM_ADDR=29'h0600002, DDRAM_BE=8'h08, DDRAM_DIN=64'h5A5A5A5A5A5A5A5A; a_ready returns high after BUSY clears.
- A read 21'h000010, DDR3 returns 64'h0706050403020100 after 5 cycles -> a_dout=8'h00; a second read at 21'h000015 (cache on) -> a_dout=8'h05 two cycles after the edge, no DDRAM_RD.
- A and B read misses rising in the same cycle, three times -> grant order A, B, then B, A, then A, B.
- B writes 8'hEE to 21'h000012 while A's line for tag 2 is valid -> A then reads 21'h000012 with a cache hit and gets 8'hEE.
- Assert reset during RWAIT, then pulse DDRAM_DOUT_READY -> no dout change, both ready=1, DDRAM_RD=0.
- DDRAM_BUSY held high 10 cycles during RD -> DDRAM_RD and DDRAM_ADDR stable throughout, exactly one accepted read.
